// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron datapath.
// Current width, Q0.16 fraction width, integrator FSM states, saturating add.
package snn_pkg;

   localparam int CURRENT_W = 16;
   localparam int FRAC_W    = 16;

   typedef enum logic {
      ACCUM = 1'b0,
      DECAY = 1'b1
   } state_t;

   // Unsigned add that clamps to all-ones instead of wrapping
   function automatic logic [CURRENT_W-1:0] sat_add(
      input logic [CURRENT_W-1:0] a,
      input logic [CURRENT_W-1:0] b
   );
      logic [CURRENT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CURRENT_W] ? {CURRENT_W{1'b1}} : s[CURRENT_W-1:0];
   endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Event buffer for presynaptic spike addresses.
// Ports: i_push/i_data in, i_pop/o_data out, o_full/o_empty status.
module spike_event_fifo
   import snn_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic [ADDR_W-1:0] i_data,
   input  logic              i_pop,
   output logic [ADDR_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty
);

   localparam int PW = $clog2(FIFO_DEPTH);

   logic [ADDR_W-1:0] r_mem [FIFO_DEPTH];
   logic [PW:0]       r_wr_ptr;
   logic [PW:0]       r_rd_ptr;
   logic              w_do_push;
   logic              w_do_pop;

   // Extra MSB on each pointer tells full apart from empty
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                    (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
   end

endmodule

// File: rtl/spike_synapse_integrator.sv
// Buffers spike addresses, accumulates their weights, leaks and publishes per tick.
// Ports: spike handshake, weight-table write, timestep/decay_factor, current out.
module spike_synapse_integrator
   import snn_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spike_valid,
   output logic                 spike_ready,
   input  logic [ADDR_W-1:0]    spike_addr,
   input  logic                 wt_wr_en,
   input  logic [ADDR_W-1:0]    wt_wr_addr,
   input  logic [CURRENT_W-1:0] wt_wr_data,
   input  logic                 timestep,
   input  logic [FRAC_W-1:0]    decay_factor,
   output logic [CURRENT_W-1:0] input_current,
   output logic                 current_valid,
   output logic                 overrun
);

   localparam int NWT = 2 ** ADDR_W;

   logic [CURRENT_W-1:0] r_wt [NWT];
   logic [CURRENT_W-1:0] r_wt_q;
   logic                 r_wt_vld;
   logic [CURRENT_W-1:0] r_acc;
   logic                 r_pending;
   logic [CURRENT_W-1:0] r_cur;
   logic                 r_cur_vld;
   logic                 r_overrun;
   state_t               r_state;
   state_t               w_state_nxt;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic [ADDR_W-1:0]    w_head;
   logic                 w_decay_en;
   logic [CURRENT_W-1:0] w_leak;
   logic [CURRENT_W-1:0] w_acc_n;

   assign spike_ready   = !w_full && !r_pending;
   assign w_push        = spike_valid && spike_ready;
   assign w_pop         = !w_empty;
   assign input_current = r_cur;
   assign current_valid = r_cur_vld;
   assign overrun       = r_overrun;

   spike_event_fifo #(
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (spike_addr),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Leak term: upper half of the 32-bit acc * Q0.16 product
   assign w_leak = CURRENT_W'(
      ({16'b0, r_acc} * {16'b0, decay_factor}) >> FRAC_W);
   assign w_acc_n = r_acc - w_leak;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NWT; i++) r_wt[i] <= '0;
      end else if (wt_wr_en) begin
         r_wt[wt_wr_addr] <= wt_wr_data;
      end
   end

   // Stage 1: pop head, read old table contents (write lands same edge)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wt_q   <= '0;
         r_wt_vld <= 1'b0;
      end else begin
         r_wt_q   <= r_wt[w_head];
         r_wt_vld <= w_pop;
      end
   end

   // Stage 2: accumulate; r_wt_vld is always clear while in DECAY
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
      end else if (w_decay_en) begin
         r_acc <= w_acc_n;
      end else if (r_wt_vld) begin
         r_acc <= sat_add(r_acc, r_wt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_decay_en)    r_pending <= 1'b0;
         else if (timestep) r_pending <= 1'b1;
         if (timestep && r_pending) r_overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cur     <= '0;
         r_cur_vld <= 1'b0;
      end else begin
         r_cur_vld <= w_decay_en;
         if (w_decay_en) r_cur <= w_acc_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ACCUM;
      else       r_state <= w_state_nxt;
   end

   // Enter DECAY once the edge leaves the pipe drained: an empty FIFO
   // with no push means no pop, so stage 2 is idle in DECAY too.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ACCUM: begin
            if ((r_pending || timestep) && w_empty && !w_push)
               w_state_nxt = DECAY;
         end
         DECAY: w_state_nxt = ACCUM;
         default: w_state_nxt = ACCUM;
      endcase
   end

   always_comb begin
      w_decay_en = 1'b0;
      unique case (r_state)
         ACCUM:   w_decay_en = 1'b0;
         DECAY:   w_decay_en = 1'b1;
         default: w_decay_en = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_spike_synapse_integrator.sv
// Directed bench for spike_synapse_integrator.
// Hand-computed expected currents, pulse counts and flags.
module tb_spike_synapse_integrator;

   logic        clk = 1'b0;
   logic        reset;
   logic        spike_valid;
   logic        spike_ready;
   logic [3:0]  spike_addr;
   logic        wt_wr_en;
   logic [3:0]  wt_wr_addr;
   logic [15:0] wt_wr_data;
   logic        timestep;
   logic [15:0] decay_factor;
   logic [15:0] input_current;
   logic        current_valid;
   logic        overrun;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spike_synapse_integrator #(
      .ADDR_W     (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .spike_valid   (spike_valid),
      .spike_ready   (spike_ready),
      .spike_addr    (spike_addr),
      .wt_wr_en      (wt_wr_en),
      .wt_wr_addr    (wt_wr_addr),
      .wt_wr_data    (wt_wr_data),
      .timestep      (timestep),
      .decay_factor  (decay_factor),
      .input_current (input_current),
      .current_valid (current_valid),
      .overrun       (overrun)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic wr_wt(input logic [3:0] a, input logic [15:0] d);
      wt_wr_en   = 1'b1;
      wt_wr_addr = a;
      wt_wr_data = d;
      tick();
      wt_wr_en = 1'b0;
   endtask

   task automatic send(input logic [3:0] a);
      bit ok;
      ok = 1'b0;
      spike_valid = 1'b1;
      spike_addr  = a;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = spike_ready;
         tick();
      end
      spike_valid = 1'b0;
      check("send_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_pulses(input int n,
                              output int cnt,
                              output logic [15:0] val);
      cnt = 0;
      val = input_current;
      for (int i = 0; i < n; i++) begin
         tick();
         if (current_valid) begin
            cnt++;
            val = input_current;
         end
      end
   endtask

   task automatic step(input string tag,
                       input logic [15:0] df,
                       input logic [15:0] exp);
      int          cnt;
      logic [15:0] val;
      timestep     = 1'b1;
      decay_factor = df;
      tick();
      timestep = 1'b0;
      wait_pulses(12, cnt, val);
      check({tag, "_cur"}, 32'(val), 32'(exp));
      check({tag, "_pulses"}, 32'(cnt), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cnt;
      int          n_acc;
      bit          rdy;
      logic [15:0] val;

      reset        = 1'b1;
      spike_valid  = 1'b0;
      spike_addr   = '0;
      wt_wr_en     = 1'b0;
      wt_wr_addr   = '0;
      wt_wr_data   = '0;
      timestep     = 1'b0;
      decay_factor = '0;
      tick();
      tick();
      reset = 1'b0;

      check("rst_ready", 32'(spike_ready), 32'd1);
      check("rst_cur", 32'(input_current), 32'h0);
      check("rst_cvld", 32'(current_valid), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);

      // Reset while three events are still draining
      wr_wt(4'd2, 16'h0100);
      send(4'd2);
      send(4'd2);
      send(4'd2);
      do_reset();
      check("mid_ready", 32'(spike_ready), 32'd1);
      check("mid_cur", 32'(input_current), 32'h0);
      check("mid_cvld", 32'(current_valid), 32'd0);
      step("mid", 16'h0000, 16'h0000);

      // Basic accumulate
      do_reset();
      wr_wt(4'd2, 16'h0100);
      wr_wt(4'd5, 16'h0030);
      send(4'd2);
      send(4'd5);
      send(4'd2);
      step("basic", 16'h0000, 16'h0230);

      // Leak: 0x1000 -> 0x0C00 -> 0x0900
      do_reset();
      wr_wt(4'd1, 16'h1000);
      send(4'd1);
      step("decay1", 16'h4000, 16'h0C00);
      step("decay2", 16'h4000, 16'h0900);

      // Maximum leak keeps the 1/65536 residual
      do_reset();
      wr_wt(4'd1, 16'h0001);
      send(4'd1);
      step("dffff", 16'hFFFF, 16'h0001);

      // Saturation
      do_reset();
      wr_wt(4'd0, 16'hF000);
      send(4'd0);
      send(4'd0);
      step("sat", 16'h0000, 16'hFFFF);

      // Backpressure: valid held 8 cycles, tick on the first
      do_reset();
      wr_wt(4'd4, 16'h0003);
      spike_valid  = 1'b1;
      spike_addr   = 4'd4;
      timestep     = 1'b1;
      decay_factor = 16'h0000;
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         rdy = spike_ready;
         if (i == 1) check("bp_ready_low", 32'(rdy), 32'd0);
         tick();
         timestep = 1'b0;
         if (rdy) n_acc++;
      end
      spike_valid = 1'b0;
      check("bp_count", 32'(n_acc), 32'd5);
      step("bp_sum", 16'h0000, 16'(n_acc * 3));

      // Overrun: two back-to-back ticks with 4 events in flight
      do_reset();
      wr_wt(4'd6, 16'h0002);
      check("ovr_before", 32'(overrun), 32'd0);
      send(4'd6);
      send(4'd6);
      send(4'd6);
      send(4'd6);
      timestep = 1'b1;
      tick();
      tick();
      timestep = 1'b0;
      wait_pulses(12, cnt, val);
      check("ovr_pulses", 32'(cnt), 32'd1);
      check("ovr_cur", 32'(val), 32'h0008);
      check("ovr_flag", 32'(overrun), 32'd1);

      // Weight write in the same cycle stage 1 reads that entry
      do_reset();
      wr_wt(4'd3, 16'h0011);
      send(4'd3);
      wr_wt(4'd3, 16'h0055);
      step("haz_old", 16'h0000, 16'h0011);
      send(4'd3);
      step("haz_new", 16'h0000, 16'h0066);
      check("haz_ovr", 32'(overrun), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
